nes_joypad_responder: RTL and testbench

//   Emulates standard NES controllers (CD4021 shift register) on the console's controller port

---
 rtl/nes_joypad_responder.sv | 96 +++++++++
 tb/tb_nes_joypad_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_joypad_responder.sv
// Pad-side NES controller emulation: CD4021-style latch and shift per port,
// driven by the console's strobe and read-clock pins.
module nes_joypad_responder #(
    parameter int NUM_PORTS    = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int TURBO_PERIOD = 800000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ctrl_strobe,
    input  logic [NUM_PORTS-1:0]   ctrl_clk_n,
    input  logic [8*NUM_PORTS-1:0] buttons,
    input  logic [NUM_PORTS-1:0]   turbo_a,
    input  logic [NUM_PORTS-1:0]   turbo_b,
    output logic [NUM_PORTS-1:0]   ctrl_data_n,
    output logic [4*NUM_PORTS-1:0] read_count
);

    localparam int TW = (TURBO_PERIOD > 1) ? $clog2(TURBO_PERIOD) : 1;
    localparam logic [TW-1:0] TURBO_LAST = TW'(TURBO_PERIOD - 1);

    logic [SYNC_STAGES-1:0] strobe_sync;
    logic                   strobe_s;
    logic [TW-1:0]          turbo_cnt;
    logic                   phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_sync <= '0;
        end else begin
            strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], ctrl_strobe};
        end
    end

    assign strobe_s = strobe_sync[SYNC_STAGES-1];

    // One shared turbo timebase so every port auto-fires in step.
    always_ff @(posedge clk) begin
        if (rst) begin
            turbo_cnt <= '0;
            phase     <= 1'b0;
        end else if (turbo_cnt == TURBO_LAST) begin
            turbo_cnt <= '0;
            phase     <= ~phase;
        end else begin
            turbo_cnt <= turbo_cnt + TW'(1);
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [SYNC_STAGES-1:0] clkn_sync;
        logic                   clkn_s;
        logic                   clkn_d;
        logic                   rise;
        logic [7:0]             btn;
        logic [7:0]             eff;
        logic [7:0]             sr;
        logic [3:0]             cnt;
        logic                   data_n;

        assign btn    = buttons[8*p +: 8];
        assign eff    = {btn[7:2],
                         btn[1] & (~turbo_b[p] | phase),
                         btn[0] & (~turbo_a[p] | phase)};
        assign clkn_s = clkn_sync[SYNC_STAGES-1];
        assign rise   = clkn_s & ~clkn_d;

        // Strobe has priority: an edge seen while latching is dropped.
        always_ff @(posedge clk) begin
            if (rst) begin
                clkn_sync <= '1;
                clkn_d    <= 1'b1;
                sr        <= '0;
                cnt       <= '0;
                data_n    <= 1'b1;
            end else begin
                clkn_sync <= {clkn_sync[SYNC_STAGES-2:0], ctrl_clk_n[p]};
                clkn_d    <= clkn_s;
                data_n    <= ~sr[0];
                if (strobe_s) begin
                    sr  <= eff;
                    cnt <= '0;
                end else if (rise) begin
                    sr <= {1'b1, sr[7:1]};
                    if (cnt != 4'hF) begin
                        cnt <= cnt + 4'd1;
                    end
                end
            end
        end

        assign ctrl_data_n[p]     = data_n;
        assign read_count[4*p +: 4] = cnt;
    end

endmodule

// File: tb/tb_nes_joypad_responder.sv
// Bench for nes_joypad_responder: console-side pin driver with a per-port
// queue of expected wire levels filled at every latch.
module tb_nes_joypad_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_strobe;
    logic [1:0]  ctrl_clk_n;
    logic [15:0] buttons;
    logic [1:0]  turbo_a;
    logic [1:0]  turbo_b;
    wire  [1:0]  ctrl_data_n;
    wire  [7:0]  read_count;

    int vectors = 0;
    int miscompares = 0;

    bit exp_q[2][$];
    int exp_cnt[2];
    int rd_idx[2];

    nes_joypad_responder #(
        .NUM_PORTS(2),
        .SYNC_STAGES(2),
        .TURBO_PERIOD(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ctrl_strobe(ctrl_strobe),
        .ctrl_clk_n(ctrl_clk_n),
        .buttons(buttons),
        .turbo_a(turbo_a),
        .turbo_b(turbo_b),
        .ctrl_data_n(ctrl_data_n),
        .read_count(read_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected wire per read: inverted latched bits, then 0 once 1s fill in.
    function automatic void model_load(input int p, input logic [7:0] b);
        exp_q[p].delete();
        for (int i = 0; i < 8; i++) exp_q[p].push_back(~b[i]);
        for (int i = 0; i < 24; i++) exp_q[p].push_back(1'b0);
        exp_cnt[p] = 0;
        rd_idx[p]  = 0;
    endfunction

    task automatic strobe_pulse();
        model_load(0, buttons[7:0]);
        model_load(1, buttons[15:8]);
        ctrl_strobe = 1'b1;
        tick(3);
        ctrl_strobe = 1'b0;
        tick(6);
    endtask

    task automatic do_read(input int p, input string name);
        bit e;
        vectors++;
        if (exp_q[p].size() == 0) begin
            miscompares++;
            $display("FAIL %s port%0d read%0d: no expected value queued",
                     name, p, rd_idx[p]);
        end else begin
            e = exp_q[p].pop_front();
            if (ctrl_data_n[p] !== e) begin
                miscompares++;
                $display("FAIL %s port%0d read%0d: got %b expected %b",
                         name, p, rd_idx[p], ctrl_data_n[p], e);
            end
        end
        ctrl_clk_n[p] = 1'b0;
        tick(2);
        ctrl_clk_n[p] = 1'b1;
        tick(6);
        if (exp_cnt[p] < 15) exp_cnt[p]++;
        rd_idx[p]++;
    endtask

    task automatic check_cnt(input string name);
        for (int p = 0; p < 2; p++) begin
            vectors++;
            if (read_count[4*p +: 4] !== 4'(exp_cnt[p])) begin
                miscompares++;
                $display("FAIL %s read_count[%0d]: got %0d expected %0d",
                         name, p, read_count[4*p +: 4], exp_cnt[p]);
            end
        end
    endtask

    task automatic check_front(input int p, input string name);
        vectors++;
        if (exp_q[p].size() == 0 || ctrl_data_n[p] !== exp_q[p][0]) begin
            miscompares++;
            $display("FAIL %s port%0d data: got %b expected %b",
                     name, p, ctrl_data_n[p],
                     (exp_q[p].size() == 0) ? 1'bx : exp_q[p][0]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ctrl_strobe = 1'b0;
        ctrl_clk_n = 2'b11;
        buttons = 16'h0000;
        turbo_a = 2'b00;
        turbo_b = 2'b00;
        tick(3);
        vectors++;
        if (ctrl_data_n !== 2'b11 || read_count !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_hold: got data %b cnt %h expected 11 00",
                     ctrl_data_n, read_count);
        end
        rst = 1'b0;
        model_load(0, 8'h00);
        model_load(1, 8'h00);
        tick(5);
        vectors++;
        if (ctrl_data_n !== 2'b11 || read_count !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_idle: got data %b cnt %h expected 11 00",
                     ctrl_data_n, read_count);
        end
    endtask

    task automatic test_serial();
        buttons = 16'h0009;
        strobe_pulse();
        check_cnt("serial_start");
        repeat (20) do_read(0, "serial");
        check_cnt("serial_sat");
    endtask

    task automatic test_strobe_held();
        buttons = 16'h0001;
        ctrl_strobe = 1'b1;
        tick(4);
        for (int i = 0; i < 5; i++) begin
            ctrl_clk_n[0] = 1'b0;
            tick(2);
            ctrl_clk_n[0] = 1'b1;
            tick(4);
            vectors++;
            if (ctrl_data_n[0] !== 1'b0 || read_count[3:0] !== 4'd0) begin
                miscompares++;
                $display("FAIL strobe_held pulse%0d: got data %b cnt %0d expected 0 0",
                         i, ctrl_data_n[0], read_count[3:0]);
            end
        end
        model_load(0, buttons[7:0]);
        model_load(1, buttons[15:8]);
        ctrl_strobe = 1'b0;
        tick(6);
        do_read(0, "strobe_release");
        do_read(0, "strobe_release");
        check_cnt("strobe_release");
    endtask

    task automatic test_turbo();
        logic s [32];
        int last_t;
        int ntrans;
        buttons = 16'h0001;
        turbo_a = 2'b01;
        ctrl_strobe = 1'b1;
        tick(8);
        for (int i = 0; i < 32; i++) begin
            s[i] = ctrl_data_n[0];
            tick(1);
        end
        last_t = -1;
        ntrans = 0;
        for (int i = 1; i < 32; i++) begin
            if (s[i] !== s[i-1]) begin
                if (last_t >= 0) begin
                    vectors++;
                    if (i - last_t != 4) begin
                        miscompares++;
                        $display("FAIL turbo_gap at %0d: got %0d expected 4",
                                 i, i - last_t);
                    end
                end
                last_t = i;
                ntrans++;
            end
        end
        vectors++;
        if (ntrans < 7) begin
            miscompares++;
            $display("FAIL turbo_toggles: got %0d expected >= 7", ntrans);
        end
        turbo_a = 2'b00;
        tick(6);
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (ctrl_data_n[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL turbo_off cycle%0d: got %b expected 0",
                         i, ctrl_data_n[0]);
            end
            tick(1);
        end
        ctrl_strobe = 1'b0;
        tick(6);
    endtask

    task automatic test_ports();
        buttons = {8'h00, 8'hFF};
        strobe_pulse();
        repeat (3) do_read(1, "ports");
        check_front(0, "ports_p0");
        check_front(1, "ports_p1");
        check_cnt("ports");
        vectors++;
        if (read_count !== 8'h30) begin
            miscompares++;
            $display("FAIL ports_cnt_bus: got %h expected 30", read_count);
        end
    endtask

    task automatic test_reset_mid_read();
        buttons = 16'h005A;
        strobe_pulse();
        repeat (3) do_read(0, "pre_rst");
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        model_load(0, 8'h00);
        model_load(1, 8'h00);
        tick(2);
        do_read(0, "post_rst");
        check_front(0, "post_rst_after");
        check_cnt("post_rst");
    endtask

    task automatic test_back_to_back();
        buttons = 16'h3C81;
        strobe_pulse();
        do_read(0, "b2b_first");
        do_read(1, "b2b_first");
        buttons = 16'hA542;
        strobe_pulse();
        check_cnt("b2b_restrobe");
        for (int i = 0; i < 9; i++) begin
            do_read(0, "b2b_second");
            do_read(1, "b2b_second");
        end
        check_cnt("b2b_end");
    endtask

    initial begin
        test_reset();
        test_serial();
        test_strobe_held();
        test_turbo();
        test_ports();
        test_reset_mid_read();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
